// File: rtl/parking_pkg.sv
// -----------------------------------------------------------------------------
// parking_pkg
// Shared definitions for the parking gate controller:
//   - gate FSM state encoding (one encoding used by both gate instances)
//   - default timing constants for the barrier timeout and the "full" lamp
//   - sat_inc16: saturating increment used by the per-state cycle counters
// -----------------------------------------------------------------------------
package parking_pkg;

    typedef logic [2:0] gate_state_t;

    localparam gate_state_t ST_IDLE    = 3'd0;
    localparam gate_state_t ST_OPEN    = 3'd1;
    localparam gate_state_t ST_PASSING = 3'd2;
    localparam gate_state_t ST_DONE    = 3'd3;
    localparam gate_state_t ST_DENY    = 3'd4;

    localparam logic [15:0] DEFAULT_TIMEOUT_CYCLES = 16'd1000;
    localparam logic [15:0] DEFAULT_DENY_CYCLES    = 16'd50;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/parking_gate_controller_if.sv
// -----------------------------------------------------------------------------
// parking_gate_controller_if
// Bundles the gate sensors, the parking-manager vacancy flags and the
// controller outputs.
//   master : sensor / manager side (drives sensors and vacancy, reads results)
//   slave  : the controller (reads sensors and vacancy, drives results)
// -----------------------------------------------------------------------------
interface parking_gate_controller_if;

    // entry gate sensors
    logic entry_detect;
    logic entry_tag_valid;
    logic entry_tag_uni;
    logic entry_pass;
    // exit gate sensors
    logic exit_detect;
    logic exit_tag_valid;
    logic exit_tag_uni;
    logic exit_pass;
    // vacancy from the parking manager
    logic uni_is_vacated_space;
    logic is_vacated_space;
    // controller outputs
    logic entry_barrier_open;
    logic exit_barrier_open;
    logic entry_full_lamp;
    logic car_entered;
    logic is_uni_car_entered;
    logic car_exited;
    logic is_uni_car_exited;

    modport master (
        output entry_detect, entry_tag_valid, entry_tag_uni, entry_pass,
        output exit_detect, exit_tag_valid, exit_tag_uni, exit_pass,
        output uni_is_vacated_space, is_vacated_space,
        input  entry_barrier_open, exit_barrier_open, entry_full_lamp,
        input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited
    );

    modport slave (
        input  entry_detect, entry_tag_valid, entry_tag_uni, entry_pass,
        input  exit_detect, exit_tag_valid, exit_tag_uni, exit_pass,
        input  uni_is_vacated_space, is_vacated_space,
        output entry_barrier_open, exit_barrier_open, entry_full_lamp,
        output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited
    );

endinterface

// File: rtl/gate_fsm.sv
// -----------------------------------------------------------------------------
// gate_fsm
// One barrier gate: IDLE -> OPEN -> PASSING -> DONE -> IDLE, plus DENY when
// the space check is enabled and the tagged class has no free space.
// Optional feature macro: GATE_TIMEOUT_EN -- OPEN and PASSING give up and
// return to IDLE (no event) after TIMEOUT_CYCLES cycles in the state.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   detect_i        car on the loop (level)
//   tag_valid_i     one-cycle tag read pulse, tag_uni_i is its class
//   pass_i          pass beam broken (level)
//   space_ok_i      vacancy for the class being tagged (used when CHECK_SPACE)
//   barrier_open_o  raise barrier (OPEN, PASSING)
//   full_lamp_o     lit while in DENY
//   event_o         one-cycle "car went through" pulse (DONE)
//   event_uni_o     latched class, qualified by event_o
// -----------------------------------------------------------------------------
module gate_fsm
    import parking_pkg::*;
#(
    parameter bit          CHECK_SPACE    = 1'b0,
    parameter logic [15:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter logic [15:0] DENY_CYCLES    = DEFAULT_DENY_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic detect_i,
    input  logic tag_valid_i,
    input  logic tag_uni_i,
    input  logic pass_i,
    input  logic space_ok_i,
    output logic barrier_open_o,
    output logic full_lamp_o,
    output logic event_o,
    output logic event_uni_o
);

`ifdef GATE_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    gate_state_t state_q, state_d;
    logic        uni_q, uni_d;
    logic        pass_q;
    logic [15:0] cnt_q, cnt_d;

    logic pass_rise;
    logic pass_fall;
    logic timed_out;
    logic deny_done;

    // Edges are taken against the previous-cycle pass level, which keeps
    // updating in IDLE; a beam already broken when OPEN is entered is not
    // an edge.
    assign pass_rise = pass_i & ~pass_q;
    assign pass_fall = ~pass_i & pass_q;

    // Counter is 0 in the first cycle of a state, so leaving when it holds
    // N-1 keeps the state for exactly N cycles.
    assign timed_out = TIMEOUT_EN && (cnt_q >= TIMEOUT_CYCLES - 16'd1);
    assign deny_done = (cnt_q >= DENY_CYCLES - 16'd1);

    always_comb begin
        state_d = state_q;
        uni_d   = uni_q;
        case (state_q)
            ST_IDLE: begin
                if (tag_valid_i && detect_i) begin
                    uni_d   = tag_uni_i;
                    state_d = (CHECK_SPACE && !space_ok_i) ? ST_DENY : ST_OPEN;
                end
            end
            ST_OPEN: begin
                if (pass_rise)
                    state_d = ST_PASSING;
                else if (!detect_i || timed_out)
                    state_d = ST_IDLE;
            end
            ST_PASSING: begin
                if (pass_fall)
                    state_d = ST_DONE;
                else if (timed_out)
                    state_d = ST_IDLE;
            end
            ST_DONE: state_d = ST_IDLE;
            ST_DENY: begin
                if (deny_done)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        cnt_d = (state_d != state_q) ? 16'd0 : sat_inc16(cnt_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            uni_q   <= 1'b0;
            pass_q  <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            uni_q   <= uni_d;
            pass_q  <= pass_i;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode the state directly so reset clears them at once.
    assign barrier_open_o = (state_q == ST_OPEN) || (state_q == ST_PASSING);
    assign full_lamp_o    = (state_q == ST_DENY);
    assign event_o        = (state_q == ST_DONE);
    assign event_uni_o    = (state_q == ST_DONE) && uni_q;

endmodule

// File: rtl/parking_gate_controller.sv
// -----------------------------------------------------------------------------
// parking_gate_controller
// Two independent gate FSMs (entry with vacancy check / DENY, exit without).
// Optional feature macro: GATE_TIMEOUT_EN (see gate_fsm).
// Ports:
//   clk    single rising-edge clock
//   reset  asynchronous active-high reset
//   bus    parking_gate_controller_if.slave: gate sensors, vacancy flags,
//          barrier commands, full lamp, entry/exit event pulses with class
// -----------------------------------------------------------------------------
module parking_gate_controller
    import parking_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter logic [15:0] DENY_CYCLES    = DEFAULT_DENY_CYCLES
) (
    input  logic                       clk,
    input  logic                       reset,
    parking_gate_controller_if.slave   bus
);

    logic entry_space_ok;
    logic entry_lamp;
    logic exit_lamp;

    // Vacancy of the class being presented, looked at in the tag cycle only.
    assign entry_space_ok = bus.entry_tag_uni ? bus.uni_is_vacated_space
                                              : bus.is_vacated_space;

    gate_fsm #(
        .CHECK_SPACE    (1'b1),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .DENY_CYCLES    (DENY_CYCLES)
    ) u_entry (
        .clk            (clk),
        .reset          (reset),
        .detect_i       (bus.entry_detect),
        .tag_valid_i    (bus.entry_tag_valid),
        .tag_uni_i      (bus.entry_tag_uni),
        .pass_i         (bus.entry_pass),
        .space_ok_i     (entry_space_ok),
        .barrier_open_o (bus.entry_barrier_open),
        .full_lamp_o    (entry_lamp),
        .event_o        (bus.car_entered),
        .event_uni_o    (bus.is_uni_car_entered)
    );

    gate_fsm #(
        .CHECK_SPACE    (1'b0),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .DENY_CYCLES    (DENY_CYCLES)
    ) u_exit (
        .clk            (clk),
        .reset          (reset),
        .detect_i       (bus.exit_detect),
        .tag_valid_i    (bus.exit_tag_valid),
        .tag_uni_i      (bus.exit_tag_uni),
        .pass_i         (bus.exit_pass),
        .space_ok_i     (1'b1),
        .barrier_open_o (bus.exit_barrier_open),
        .full_lamp_o    (exit_lamp),
        .event_o        (bus.car_exited),
        .event_uni_o    (bus.is_uni_car_exited)
    );

    // The exit instance never enters DENY, so its lamp term is always 0;
    // it is merged so the lamp reflects any gate in DENY.
    assign bus.entry_full_lamp = entry_lamp | exit_lamp;

endmodule

// File: doc/parking_gate_controller.md
PARKING_GATE_CONTROLLER -- requirements
Module: parking_gate_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd1000, meaning max cycles the barrier stays open waiting for pass-beam activity.
REQ-002 SHALL have parameter DENY_CYCLES, default 16'd50, meaning cycles entry_full_lamp stays lit after a refused entry.
REQ-003 SHALL have ports:
  clk  in  1  single clock, all logic rising-edge;
  reset  in  1  asynchronous, active-high;
  entry_detect  in  1  car present on entry loop (level);
  entry_tag_valid  in  1  one-cycle pulse, entry tag read;
  entry_tag_uni  in  1  entry tag is university class, valid with entry_tag_valid;
  entry_pass  in  1  entry pass beam broken (level);
  exit_detect, exit_tag_valid, exit_tag_uni, exit_pass  in  1 each  same meaning for the exit gate;
  uni_is_vacated_space  in  1  university space free, from parking manager;
  is_vacated_space  in  1  public space free, from parking manager;
  entry_barrier_open, exit_barrier_open  out  1 each  barrier raise command;
  entry_full_lamp  out  1  "full" indicator;
  car_entered, is_uni_car_entered  out  1 each  one-cycle entry event + class, to parking manager;
  car_exited, is_uni_car_exited  out  1 each  one-cycle exit event + class, to parking manager.

Function
REQ-004 Each gate SHALL run an independent FSM: IDLE, OPEN, PASSING, DONE, DENY (DENY reachable only on entry gate).
REQ-005 IDLE: on tag_valid=1 with detect=1, SHALL latch tag_uni and leave IDLE next cycle; tag_valid with detect=0 SHALL be ignored.
REQ-006 Entry gate SHALL go IDLE->DENY if the latched class's vacancy input (uni_is_vacated_space or is_vacated_space) is 0 in the tag_valid cycle, else IDLE->OPEN; exit gate SHALL always go IDLE->OPEN.
REQ-007 OPEN: barrier_open=1; pass rising (registered 0->1) SHALL move to PASSING; detect=0 before pass rising SHALL return to IDLE with no event.
REQ-008 PASSING: barrier_open=1; pass falling (1->0) SHALL move to DONE; detect changes are ignored.
REQ-009 DONE: barrier_open=0; SHALL assert car_entered (or car_exited) for exactly one cycle with is_uni_* equal to the latched class; then IDLE.
REQ-010 is_uni_car_entered/is_uni_car_exited SHALL be 0 whenever the matching event pulse is 0.
REQ-011 DENY: entry_full_lamp=1, barrier closed, for exactly DENY_CYCLES cycles, then IDLE.
REQ-012 tag_valid in any non-IDLE state SHALL be ignored; no queuing.
REQ-013 Entry and exit events in the same cycle SHALL both be emitted; no arbitration.
REQ-014 Pass inputs SHALL be registered one stage for edge detection; an already-high pass in IDLE SHALL NOT count as a rising edge on entering OPEN.
REQ-015 Cycle counters SHALL be 16-bit, saturating, cleared on every state entry.

Reset
REQ-016 Reset SHALL asynchronously force both FSMs to IDLE, all outputs 0, latched class 0, counters 0, pass history registers 0.
REQ-017 Reset mid-transaction SHALL discard it with no event pulse after release.

Configuration
REQ-018 With GATE_TIMEOUT_EN defined, OPEN and PASSING SHALL return to IDLE with no event when the state counter reaches TIMEOUT_CYCLES.
REQ-019 Without GATE_TIMEOUT_EN, OPEN and PASSING SHALL wait indefinitely; TIMEOUT_CYCLES is unused.

Structure
REQ-020 Shared package parking_pkg SHALL hold the gate state enumeration and default TIMEOUT/DENY constants.
REQ-021 Per-gate logic SHALL be one sub-module gate_fsm, instantiated twice, with a parameter enabling the space check/DENY path for the entry instance only.

Verification
REQ-022 Public entry: detect=1, tag_valid pulse tag_uni=0, is_vacated_space=1, pass 1 for 3 cycles then 0 -> barrier open from next cycle, car_entered=1 and is_uni_car_entered=0 for one cycle after pass falls.
REQ-023 Uni entry when full: uni_is_vacated_space=0, tag_uni=1 -> barrier never opens, entry_full_lamp=1 for 50 cycles, no car_entered.
REQ-024 Abort: open gate, drop detect before pass -> IDLE, barrier 0, no event.
REQ-025 Timeout (GATE_TIMEOUT_EN, TIMEOUT_CYCLES=10): open, no pass, detect held -> barrier drops after 10 cycles, no event; without macro barrier stays open 100+ cycles.
REQ-026 Concurrent: uni exit and public entry complete in same cycle -> car_exited=1,is_uni_car_exited=1 and car_entered=1,is_uni_car_entered=0 together.
REQ-027 Reset asserted in PASSING -> all outputs 0 immediately; no pulse after release even if pass then falls.
